// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch path
// and the load/store path of a processor core. Each requester uses a
// req/ready handshake; the memory side sees one registered request that is
// held until the memory acknowledges.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin between fetch and data
//                                        when both request in the same cycle
//                           undefined -> fixed priority, data always wins
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   if_req     in   fetch request, held with if_addr until if_ready
//   if_addr    in   fetch word address
//   if_ready   out  one-cycle pulse, if_rdata valid
//   if_rdata   out  fetched instruction (shared read register)
//   d_req      in   data request, held with d_we/d_addr/d_wdata until d_ready
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data address
//   d_wdata    in   store data
//   d_ready    out  one-cycle pulse, load data valid / store complete
//   d_rdata    out  load data (shared read register)
//   mem_req    out  memory request, held until mem_ready
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_ready  in   memory acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  in   memory read data
//   busy       out  high in every state except idle
//
// All outputs come straight from registers or from decodes of the state
// register, so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GNT_I  = 3'd1;
    localparam logic [2:0] GNT_D  = 3'd2;
    localparam logic [2:0] RESP_I = 3'd3;
    localparam logic [2:0] RESP_D = 3'd4;

    logic [2:0]    state_q,     state_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q,     rdata_d;

    // Winner selection for the current idle cycle.
    logic pick_d;
    logic pick_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data has priority on a tie, 0 = fetch has priority on a tie.
    logic prio_q, prio_d;

    assign pick_d = d_req & (~if_req | prio_q);
`else
    assign pick_d = d_req;
`endif
    assign pick_i = if_req & ~pick_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_d      = prio_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = GNT_D;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (pick_i) begin
                    // Fetch never writes; write data is left as it was.
                    state_d     = GNT_I;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                end
            end

            GNT_I: begin
                if (mem_ready) begin
                    state_d = RESP_I;
                    rdata_d = mem_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    prio_d  = 1'b1;
`endif
                end
            end

            GNT_D: begin
                if (mem_ready) begin
                    // Captured for stores too; the value is simply unused then.
                    state_d = RESP_D;
                    rdata_d = mem_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    prio_d  = 1'b0;
`endif
                end
            end

            // Requests are not sampled here: the requester only updates its
            // request on the edge that ends the ready pulse.
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b1;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // -----------------------------------------------------------------------
    assign mem_req   = (state_q == GNT_I) || (state_q == GNT_D);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_ready  = (state_q == RESP_I);
    assign d_ready   = (state_q == RESP_D);
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;

    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    // One record per clock: inputs driven during the cycle, expected outputs
    // just after the following rising edge.
    // flags = {if_ready, d_ready, mem_req, mem_we, busy}
    typedef struct {
        string       name;
        logic        rst;
        logic        ireq;
        logic [31:0] ia;
        logic        dreq;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dw;
        logic        mr;
        logic [31:0] md;
        logic [4:0]  e_flags;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic rst, logic ireq, logic [31:0] ia,
                                logic dreq, logic dwe, logic [31:0] da, logic [31:0] dw,
                                logic mr, logic [31:0] md, logic [4:0] ef,
                                logic [31:0] ea, logic [31:0] ew, logic [31:0] er);
        vec_t x;
        x.name = nm;   x.rst = rst; x.ireq = ireq; x.ia = ia;
        x.dreq = dreq; x.dwe = dwe; x.da = da;     x.dw = dw;
        x.mr = mr;     x.md = md;   x.e_flags = ef;
        x.e_addr = ea; x.e_wdata = ew; x.e_rdata = er;
        vecs.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The two ready pulses must never coincide.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (if_ready && d_ready) begin
                bad++;
                $display("FAIL ready_overlap at %0t: if_ready=%b d_ready=%b required not both 1",
                         $time, if_ready, d_ready);
            end
        end
    end

    initial begin
        logic [4:0] act_flags;
        logic       exp_d;
        int         n;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0;  d_wdata = '0;  mem_ready = 1'b0; mem_rdata = '0;

        //  name            rst ireq ia     dreq we da     dw            mr md            flags     addr   wdata         rdata
        add("reset",        1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00000, 32'h0,   32'h0,        32'h0);
        add("idle",         0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00000, 32'h0,   32'h0,        32'h0);
        add("f_req",        0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00101, 32'h10,  32'h0,        32'h0);
        add("f_ack",        0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 32'h00500093, 5'b10001, 32'h10,  32'h0,        32'h00500093);
        add("f_resp",       0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00000, 32'h10,  32'h0,        32'h00500093);
        add("idle_mrdy",    0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'hBAD0BAD0, 5'b00000, 32'h10,  32'h0,        32'h00500093);
        add("idle_mrdy2",   0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'hBAD0BAD0, 5'b00000, 32'h10,  32'h0,        32'h00500093);
        add("st_req",       0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        5'b00111, 32'h100, 32'hDEADBEEF, 32'h00500093);
        add("st_wait1",     0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        5'b00111, 32'h100, 32'hDEADBEEF, 32'h00500093);
        add("st_wait2",     0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        5'b00111, 32'h100, 32'hDEADBEEF, 32'h00500093);
        add("st_wait3",     0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        5'b00111, 32'h100, 32'hDEADBEEF, 32'h00500093);
        add("st_ack",       0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 1, 32'h55555555, 5'b01011, 32'h100, 32'hDEADBEEF, 32'h55555555);
        add("st_resp",      0, 0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        5'b00010, 32'h100, 32'hDEADBEEF, 32'h55555555);
        add("ld_f_req",     0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00101, 32'h20,  32'hDEADBEEF, 32'h55555555);
        add("ld_f_ack",     0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        1, 32'h11,       5'b10001, 32'h20,  32'hDEADBEEF, 32'h11);
        add("ld_f_resp",    0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00000, 32'h20,  32'hDEADBEEF, 32'h11);
        add("ld_d_req",     0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        0, 32'h0,        5'b00101, 32'h200, 32'h0,        32'h11);
        add("ld_d_ack",     0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        1, 32'h22,       5'b01001, 32'h200, 32'h0,        32'h22);
        add("ld_d_resp",    0, 0, 32'h0,  1, 0, 32'h200, 32'h0,        0, 32'h0,        5'b00000, 32'h200, 32'h0,        32'h22);
        add("rst_gnt_req",  0, 0, 32'h0,  1, 1, 32'h300, 32'hCAFEF00D, 0, 32'h0,        5'b00111, 32'h300, 32'hCAFEF00D, 32'h22);
        add("rst_in_gnt",   1, 0, 32'h0,  1, 1, 32'h300, 32'hCAFEF00D, 0, 32'h0,        5'b00000, 32'h0,   32'h0,        32'h0);
        add("rst_late_ack", 0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'h77,       5'b00000, 32'h0,   32'h0,        32'h0);
        add("rst_after",    0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        5'b00000, 32'h0,   32'h0,        32'h0);

        mon_en = 1'b1;
        foreach (vecs[k]) begin
            reset   = vecs[k].rst;  if_req  = vecs[k].ireq; if_addr = vecs[k].ia;
            d_req   = vecs[k].dreq; d_we    = vecs[k].dwe;  d_addr  = vecs[k].da;
            d_wdata = vecs[k].dw;   mem_ready = vecs[k].mr; mem_rdata = vecs[k].md;
            step();
            act_flags = {if_ready, d_ready, mem_req, mem_we, busy};
            total++;
            if (act_flags !== vecs[k].e_flags || mem_addr !== vecs[k].e_addr ||
                mem_wdata !== vecs[k].e_wdata || if_rdata !== vecs[k].e_rdata ||
                d_rdata !== vecs[k].e_rdata) begin
                bad++;
                $display("FAIL %s: got flags=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h, need flags=%b addr=%h wdata=%h rdata=%h",
                         vecs[k].name, act_flags, mem_addr, mem_wdata, if_rdata, d_rdata,
                         vecs[k].e_flags, vecs[k].e_addr, vecs[k].e_wdata, vecs[k].e_rdata);
            end
        end

        // Both requesters held across four zero-wait transactions.
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            n = 0;
            while (!mem_req && n < 10) begin
                step();
                n++;
            end
            total++;
            if (n >= 10 || mem_addr !== (exp_d ? 32'h80 : 32'h40)) begin
                bad++;
                $display("FAIL both_grant%0d: mem_req=%b mem_addr=%h, need mem_req=1 mem_addr=%h",
                         t, mem_req, mem_addr, exp_d ? 32'h80 : 32'h40);
            end
            n = 0;
            while (!(if_ready || d_ready) && n < 10) begin
                step();
                n++;
            end
            total++;
            if (n >= 10 || d_ready !== exp_d || if_ready !== !exp_d) begin
                bad++;
                $display("FAIL both_ready%0d: if_ready=%b d_ready=%b, need if_ready=%b d_ready=%b",
                         t, if_ready, d_ready, !exp_d, exp_d);
            end
        end

        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        step();
        step();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
